// File: rtl/uart_arb_pkg.sv
// Shared constants for the UART transmit arbiter: byte width, FSM state
// encodings and the index-width helper used for requester numbers.
package uart_arb_pkg;

    localparam int BYTE_W = 8;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_LOCK = 1'b1;

    // Width of a requester index; never less than one bit so NREQ=1 still builds.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_arb_rr_pick.sv
// Combinational requester picker: returns the first asserted request found
// searching upward from 'start' (wrapping), or from index 0 when fixed_prio
// is set. 'any' flags that at least one request is present.
module uart_arb_rr_pick
    import uart_arb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IW   = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   start,
    input  logic            fixed_prio,
    output logic [IW-1:0]   winner,
    output logic            any
);

    int unsigned base;
    int unsigned idx;
    logic [IW-1:0] idx_n;

    // Scan NREQ positions from the base; the first hit wins.
    always_comb begin
        winner = '0;
        any    = 1'b0;
        idx    = '0;
        idx_n  = '0;
        base   = fixed_prio ? 32'd0 : 32'(start);
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx   = (base + k) % NREQ;
            idx_n = IW'(idx);
            if (!any && req[idx_n]) begin
                winner = idx_n;
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_transmitter between NREQ message sources. A granted
// requester keeps the line until its byte flagged 'last' is taken by the
// transmitter, or until it stalls for TIMEOUT cycles (0 disables that).
// A one-byte holding register feeds tx_data/tx_valid.
// Build option: define UART_ARB_FIXED_PRIO_EN to arbitrate by lowest index
// instead of round-robin.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 1023
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [BYTE_W*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]        req_last,
    output logic [NREQ-1:0]        req_ready,
    output logic [BYTE_W-1:0]      tx_data,
    output logic                   tx_valid,
    input  logic                   tx_nextch,
    output logic [NREQ-1:0]        grant,
    output logic                   timeout
);

    localparam int IW = idx_w(NREQ);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

`ifdef UART_ARB_FIXED_PRIO_EN
    localparam logic FIXED_PRIO = 1'b1;
`else
    localparam logic FIXED_PRIO = 1'b0;
`endif

    logic              state;
    logic [IW-1:0]     last_grant;
    logic [IW-1:0]     start_idx;
    logic [IW-1:0]     winner;
    logic              any_req;
    logic [NREQ-1:0]   win_onehot;
    logic              buf_last;
    logic [CW-1:0]     stall_cnt;
    logic              owner_valid;
    logic              owner_last;
    logic [BYTE_W-1:0] owner_data;
    logic              load;
    logic              stall;
    logic              to_hit;

    // Round-robin search starts just past the previous winner, wrapping.
    always_comb begin
        if (int'(last_grant) == NREQ - 1) begin
            start_idx = '0;
        end else begin
            start_idx = last_grant + 1'b1;
        end
    end

    uart_arb_rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req        (req_valid),
        .start      (start_idx),
        .fixed_prio (FIXED_PRIO),
        .winner     (winner),
        .any        (any_req)
    );

    // Decode the winner index to a one-hot grant vector.
    always_comb begin
        win_onehot = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            win_onehot[i] = (winner == IW'(i));
        end
    end

    // last_grant doubles as the owner index while locked; select its inputs.
    always_comb begin
        owner_valid = 1'b0;
        owner_last  = 1'b0;
        owner_data  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (last_grant == IW'(i)) begin
                owner_valid = req_valid[i];
                owner_last  = req_last[i];
                owner_data  = req_data[i*BYTE_W +: BYTE_W];
            end
        end
    end

    // Owner may hand over a byte only while the holding register is empty.
    always_comb begin
        req_ready = (state == ST_LOCK && !tx_valid) ? grant : '0;
        load      = (state == ST_LOCK) && !tx_valid && owner_valid;
        stall     = (state == ST_LOCK) && !tx_valid && !owner_valid;
        to_hit    = 1'b0;
        if (TIMEOUT > 0) begin
            to_hit = stall && (stall_cnt == CW'(TIMEOUT - 1));
        end
    end

    // Arbitration FSM, holding register and stall timer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            grant      <= '0;
            last_grant <= IW'(NREQ - 1);
            tx_data    <= '0;
            tx_valid   <= 1'b0;
            buf_last   <= 1'b0;
            stall_cnt  <= '0;
            timeout    <= 1'b0;
        end else begin
            timeout <= 1'b0;

            if (tx_nextch && tx_valid) begin
                tx_valid <= 1'b0;
                if (buf_last && state == ST_LOCK) begin
                    grant <= '0;
                    state <= ST_IDLE;
                end
            end

            if (state == ST_IDLE) begin
                if (any_req) begin
                    grant      <= win_onehot;
                    last_grant <= winner;
                    state      <= ST_LOCK;
                    stall_cnt  <= '0;
                end
            end else begin
                if (load) begin
                    tx_data   <= owner_data;
                    buf_last  <= owner_last;
                    tx_valid  <= 1'b1;
                    stall_cnt <= '0;
                end else if (to_hit) begin
                    timeout   <= 1'b1;
                    grant     <= '0;
                    state     <= ST_IDLE;
                    stall_cnt <= '0;
                end else if (stall && TIMEOUT > 0) begin
                    stall_cnt <= stall_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter (NREQ=2, TIMEOUT=16): a
// cycle-accurate vector table followed by message-level sequences.
module tb_uart_tx_arbiter;

    logic       clk;
    logic       rst;
    logic       v0, v1, l0, l1;
    logic [7:0] d0, d1;
    logic       tx_nextch;
    logic [1:0] req_ready;
    logic [1:0] grant;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       timeout;

    int nvec = 0;
    int nmis = 0;

    uart_tx_arbiter #(
        .NREQ    (2),
        .TIMEOUT (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid ({v1, v0}),
        .req_data  ({d1, d0}),
        .req_last  ({l1, l0}),
        .req_ready (req_ready),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_nextch (tx_nextch),
        .grant     (grant),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [1:0]  rv;
        logic [15:0] rd;
        logic [1:0]  rl;
        logic        nx;
        logic [1:0]  g;
        logic [1:0]  rr;
        logic        tv;
        logic [7:0]  td;
        logic        to;
    } vec_t;

    typedef struct {
        logic [7:0] b;
        logic       l;
    } item_t;

    vec_t       tbl[12];
    item_t      q0[$];
    item_t      q1[$];
    logic [7:0] got[$];

    int         cyc, start1, period;
    int         stall, to_cyc, to_cnt, g1_cyc, rdy1_viol, gbad;
    logic [1:0] first_grant;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_str(input string name, input string exp);
        chk({name, "_len"}, got.size(), exp.len());
        for (int i = 0; i < exp.len() && i < got.size(); i++) begin
            chk(name, {24'd0, got[i]}, {24'd0, exp[i]});
        end
    endtask

    task automatic load_q(input int r, input string s, input logic last_on_end);
        item_t it;
        for (int i = 0; i < s.len(); i++) begin
            it.b = s[i];
            it.l = last_on_end && (i == s.len() - 1);
            if (r == 0) q0.push_back(it);
            else        q1.push_back(it);
        end
    endtask

    task automatic drive_src();
        v0 = (q0.size() > 0);
        d0 = v0 ? q0[0].b : 8'h00;
        l0 = v0 ? q0[0].l : 1'b0;
        v1 = (cyc >= start1) && (q1.size() > 0);
        d1 = v1 ? q1[0].b : 8'h00;
        l1 = v1 ? q1[0].l : 1'b0;
    endtask

    task automatic clr_mon();
        got.delete();
        cyc = 0; stall = 0; to_cyc = -1; to_cnt = 0; g1_cyc = -1;
        rdy1_viol = 0; gbad = 0; first_grant = 2'b00;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        q0.delete();
        q1.delete();
        start1 = 0;
        tx_nextch = 1'b0;
        cyc = 0;
        drive_src();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_grant", grant, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_timeout", timeout, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        clr_mon();
    endtask

    // Sources present queued bytes and advance on acceptance; the sink pulses
    // tx_nextch every 'period' cycles while tx_valid and logs what it took.
    task automatic run(input string name, input int nbytes, input int budget);
        int   sinkcnt;
        logic a0, a1, ok;
        sinkcnt = 0;
        ok = 1'b0;
        drive_src();
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            a0 = v0 & req_ready[0];
            a1 = v1 & req_ready[1];
            if (tx_nextch && tx_valid) got.push_back(tx_data);
            if (grant == 2'b01 && req_ready[1]) rdy1_viol++;
            if (grant == 2'b01 && !tx_valid && !v0) stall++;
            if (timeout) begin
                to_cnt++;
                if (to_cyc < 0) to_cyc = c;
            end
            if (grant == 2'b10 && g1_cyc < 0) g1_cyc = c;
            if (first_grant != 2'b00 && grant != 2'b01) gbad++;
            if (grant != 2'b00 && first_grant == 2'b00) first_grant = grant;
            @(posedge clk);
            #1;
            if (a0) void'(q0.pop_front());
            if (a1) void'(q1.pop_front());
            tx_nextch = 1'b0;
            sinkcnt++;
            if (tx_valid && sinkcnt >= period) begin
                tx_nextch = 1'b1;
                sinkcnt = 0;
            end
            cyc = c + 1;
            drive_src();
            if (got.size() >= nbytes) begin
                ok = 1'b1;
                break;
            end
        end
        tx_nextch = 1'b0;
        chk({name, "_done"}, ok, 1);
    endtask

    initial begin
        // Cycle table: inputs held for one cycle, outputs expected mid-cycle.
        tbl[0]  = '{2'b01, 16'h0048, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 8'h00, 1'b0};
        tbl[1]  = '{2'b01, 16'h0048, 2'b00, 1'b0, 2'b01, 2'b01, 1'b0, 8'h00, 1'b0};
        tbl[2]  = '{2'b01, 16'h0069, 2'b01, 1'b0, 2'b01, 2'b00, 1'b1, 8'h48, 1'b0};
        tbl[3]  = '{2'b01, 16'h0069, 2'b01, 1'b1, 2'b01, 2'b00, 1'b1, 8'h48, 1'b0};
        tbl[4]  = '{2'b01, 16'h0069, 2'b01, 1'b0, 2'b01, 2'b01, 1'b0, 8'h48, 1'b0};
        tbl[5]  = '{2'b10, 16'h4300, 2'b10, 1'b0, 2'b01, 2'b00, 1'b1, 8'h69, 1'b0};
        tbl[6]  = '{2'b10, 16'h4300, 2'b10, 1'b1, 2'b01, 2'b00, 1'b1, 8'h69, 1'b0};
        tbl[7]  = '{2'b10, 16'h4300, 2'b10, 1'b0, 2'b00, 2'b00, 1'b0, 8'h69, 1'b0};
        tbl[8]  = '{2'b10, 16'h4300, 2'b10, 1'b0, 2'b10, 2'b10, 1'b0, 8'h69, 1'b0};
        tbl[9]  = '{2'b00, 16'h0000, 2'b00, 1'b0, 2'b10, 2'b00, 1'b1, 8'h43, 1'b0};
        tbl[10] = '{2'b00, 16'h0000, 2'b00, 1'b1, 2'b10, 2'b00, 1'b1, 8'h43, 1'b0};
        tbl[11] = '{2'b00, 16'h0000, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 8'h43, 1'b0};

        rst = 1'b1;
        period = 1;
        apply_reset();
        for (int k = 0; k < 12; k++) begin
            {v1, v0}  = tbl[k].rv;
            {d1, d0}  = tbl[k].rd;
            {l1, l0}  = tbl[k].rl;
            tx_nextch = tbl[k].nx;
            @(negedge clk);
            chk($sformatf("vec%0d_grant", k), grant, tbl[k].g);
            chk($sformatf("vec%0d_ready", k), req_ready, tbl[k].rr);
            chk($sformatf("vec%0d_tx_valid", k), tx_valid, tbl[k].tv);
            chk($sformatf("vec%0d_tx_data", k), tx_data, tbl[k].td);
            chk($sformatf("vec%0d_timeout", k), timeout, tbl[k].to);
            @(posedge clk);
            #1;
        end
        tx_nextch = 1'b0;

        // Single message with a slow transmitter.
        apply_reset();
        load_q(0, "Hi\r\n", 1'b1);
        period = 20;
        run("single", 4, 200);
        chk_str("single_seq", "Hi\r\n");
        chk("single_first_grant", first_grant, 2'b01);
        chk("single_grant_hold", gbad, 0);
        chk("single_grant_after", grant, 2'b00);

        // Both requesters contend from reset, two messages each.
        apply_reset();
        load_q(0, "AB", 1'b1);
        load_q(0, "AB", 1'b1);
        load_q(1, "CD", 1'b1);
        load_q(1, "CD", 1'b1);
        period = 3;
        run("cont", 8, 400);
`ifdef UART_ARB_FIXED_PRIO_EN
        chk_str("cont_seq", "ABABCDCD");
`else
        chk_str("cont_seq", "ABCDABCD");
`endif
        chk("cont_ready1_during_r0", rdy1_viol, 0);

        // Requester 1 arrives in the middle of requester 0's message.
        apply_reset();
        load_q(0, "PQR", 1'b1);
        load_q(1, "xy", 1'b1);
        start1 = 4;
        period = 5;
        run("intl", 5, 300);
        chk_str("intl_seq", "PQRxy");
        chk("intl_ready1_during_r0", rdy1_viol, 0);

        // Owner stalls after a non-last byte; requester 1 waits behind it.
        apply_reset();
        load_q(0, "X", 1'b0);
        load_q(1, "Z", 1'b1);
        period = 1;
        run("tmo", 2, 100);
        chk_str("tmo_seq", "XZ");
        chk("tmo_stall_cycles", stall, 16);
        chk("tmo_pulse_count", to_cnt, 1);
        chk("tmo_next_grant", g1_cyc, to_cyc + 1);

        // Asynchronous reset while a byte is held.
        apply_reset();
        load_q(0, "LONG", 1'b1);
        period = 20;
        run("rstmid_pre", 1, 200);
        begin
            int i;
            i = 0;
            @(negedge clk);
            while (!tx_valid && i < 40) begin
                @(negedge clk);
                i++;
            end
        end
        chk("rstmid_busy", tx_valid, 1);
        chk("rstmid_granted", grant, 2'b01);
        #1 rst = 1'b1;
        #1;
        chk("rstmid_tx_valid", tx_valid, 0);
        chk("rstmid_grant", grant, 0);
        chk("rstmid_ready", req_ready, 0);
        chk("rstmid_tx_data", tx_data, 0);
        @(posedge clk);
        #1;
        q0.delete();
        q1.delete();
        load_q(0, "M", 1'b1);
        load_q(1, "N", 1'b1);
        clr_mon();
        start1 = 0;
        period = 2;
        rst = 1'b0;
        run("rstmid_post", 2, 100);
        chk("rstmid_first_grant", first_grant, 2'b01);
        chk_str("rstmid_seq", "MN");

        // tx_nextch while the buffer is empty must be ignored.
        apply_reset();
        v0 = 1'b1; d0 = 8'h53; l0 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        v0 = 1'b0; d0 = 8'h00;
        tx_nextch = 1'b1;
        @(posedge clk); #1;
        tx_nextch = 1'b0;
        @(posedge clk); #1;
        tx_nextch = 1'b1;
        @(negedge clk);
        chk("spur_pre_tx_valid", tx_valid, 0);
        chk("spur_pre_tx_data", tx_data, 8'h53);
        @(posedge clk); #1;
        tx_nextch = 1'b0;
        @(negedge clk);
        chk("spur_grant", grant, 2'b01);
        chk("spur_ready", req_ready, 2'b01);
        chk("spur_tx_valid", tx_valid, 0);
        chk("spur_tx_data", tx_data, 8'h53);
        chk("spur_timeout", timeout, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
